// File: rtl/tx_resp_scheduler.sv
// tx_resp_scheduler: queues RdData/ALU_OUT responses and feeds them byte by byte to UART_TX
//   Inputs : clk, reset (async, active-low), RdData/RdData_Valid, ALU_OUT/OUT_VALID, Busy
//   Outputs: TX_P_DATA/TX_D_VLD (one-cycle issue strobe), q_full, overflow (sticky)
//   Macro  : TX_SCHED_ALU_MSB_FIRST_EN sends the ALU high byte first (default: low byte first)
module tx_resp_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_VALID,
    input  logic                    Busy,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    q_full,
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(ACK_TIMEOUT);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, WAIT_ACK = 2'd1, WAIT_DONE = 2'd2;

    logic [2*DATA_WIDTH:0] mem_q [DEPTH];
    logic [2*DATA_WIDTH:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] occ_q, occ_d, free;
    logic [1:0] state_q, state_d;
    logic byte_idx_q, byte_idx_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d, cur_byte;
    logic tx_vld_q, tx_vld_d, full_q, full_d, ovf_q, ovf_d;
    logic rd_acc, alu_acc, pop, last_byte;
    logic [2*DATA_WIDTH:0] head;

    always_comb begin
        free = DEPTH_C - occ_q;
        rd_acc = RdData_Valid && free != '0;
        // the ALU entry needs a second free slot when a read response arrives with it
        alu_acc = OUT_VALID && (free > (AW+1)'(RdData_Valid));
        head = mem_q[rd_q];
        last_byte = !head[2*DATA_WIDTH] || byte_idx_q;
`ifdef TX_SCHED_ALU_MSB_FIRST_EN
        cur_byte = (head[2*DATA_WIDTH] && !byte_idx_q) ? head[2*DATA_WIDTH-1:DATA_WIDTH] : head[DATA_WIDTH-1:0];
`else
        cur_byte = (head[2*DATA_WIDTH] && byte_idx_q) ? head[2*DATA_WIDTH-1:DATA_WIDTH] : head[DATA_WIDTH-1:0];
`endif
        state_d = state_q;
        byte_idx_d = byte_idx_q;
        tmo_d = tmo_q;
        tx_vld_d = 1'b0;
        tx_data_d = tx_data_q;
        pop = 1'b0;
        case (state_q)
            IDLE: if (occ_q != '0 && !Busy) begin
                tx_vld_d = 1'b1;
                tx_data_d = cur_byte;
                tmo_d = '0;
                state_d = WAIT_ACK;
            end
            // Busy is ignored during the issue cycle itself; the counter runs from the issue
            WAIT_ACK: if (!tx_vld_q && Busy) begin
                state_d = WAIT_DONE;
            end else if (tmo_q == CW'(ACK_TIMEOUT-1)) begin
                tx_vld_d = 1'b1;
                tx_data_d = cur_byte;
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
            WAIT_DONE: if (!Busy) begin
                state_d = IDLE;
                pop = last_byte;
                byte_idx_d = !last_byte;
            end
            default: state_d = IDLE;
        endcase
        mem_d = mem_q;
        if (rd_acc) mem_d[wr_q] = {1'b0, {DATA_WIDTH{1'b0}}, RdData};
        if (alu_acc) mem_d[wr_q + AW'(rd_acc)] = {1'b1, ALU_OUT};
        wr_d = wr_q + AW'(rd_acc) + AW'(alu_acc);
        rd_d = rd_q + AW'(pop);
        occ_d = occ_q + (AW+1)'(rd_acc) + (AW+1)'(alu_acc) - (AW+1)'(pop);
        full_d = occ_d == DEPTH_C;
        ovf_d = ovf_q || (RdData_Valid && !rd_acc) || (OUT_VALID && !alu_acc);
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
            occ_q <= '0;
            state_q <= IDLE;
            byte_idx_q <= 1'b0;
            tmo_q <= '0;
            tx_data_q <= '0;
            tx_vld_q <= 1'b0;
            full_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            occ_q <= occ_d;
            state_q <= state_d;
            byte_idx_q <= byte_idx_d;
            tmo_q <= tmo_d;
            tx_data_q <= tx_data_d;
            tx_vld_q <= tx_vld_d;
            full_q <= full_d;
            ovf_q <= ovf_d;
        end
    end

    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD = tx_vld_q;
    assign q_full = full_q;
    assign overflow = ovf_q;
endmodule
